// File: rtl/dclab_pkg.sv
// Shared constants and types for the dice-lab result recorder.
// Holds the 7-seg hex table, the blank code and the roll-tracking states.
package dclab_pkg;

    // Active-low {g,f,e,d,c,b,a}; all segments off.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        S_IDLE,
        S_ROLL
    } rec_state_e;

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational 4-bit to 7-seg decoder with a blank override.
// Ports: i_hex value, i_blank forces all segments off, o_seg active-low {g..a}.
module seg7_hex_decoder
    import dclab_pkg::*;
(
    input  logic [3:0] i_hex,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    assign o_seg = i_blank ? SEG_BLANK : SEG_HEX[i_hex];

endmodule

// File: rtl/rng_result_recorder.sv
// Records the final value of each random roll into a DEPTH-entry ring and
// drives a live/newest digit plus a history digit browsed with i_prev.
// Ports: i_clk, i_rst_n (async low), i_rand, i_busy, i_prev, i_clear in;
//        o_seg_cur, o_seg_hist, o_hist_idx, o_count, o_capture out (registered).
module rng_result_recorder
    import dclab_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [W-1:0]             i_rand,
    input  logic                     i_busy,
    input  logic                     i_prev,
    input  logic                     i_clear,
    output logic [6:0]               o_seg_cur,
    output logic [6:0]               o_seg_hist,
    output logic [$clog2(DEPTH)-1:0] o_hist_idx,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_capture
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // state mirrors busy_d: S_ROLL means i_busy was high last cycle
    rec_state_e    state;
    logic [W-1:0]  ring   [DEPTH];
    logic [W-1:0]  ring_n [DEPTH];
    logic [AW-1:0] wp, wp_n;
    logic [AW-1:0] idx_n;
    logic [CW-1:0] count_n;
    logic          cap_n;
    logic          roll_end;

    logic [W-1:0]  cur_val, hist_val;
    logic          cur_blank, hist_blank;
    logic [6:0]    cur_seg, hist_seg;

    assign roll_end = (state == S_ROLL) && !i_busy;

    // Clear outranks a capture, and a capture outranks i_prev.
    always_comb begin
        ring_n  = ring;
        wp_n    = wp;
        count_n = o_count;
        idx_n   = o_hist_idx;
        cap_n   = 1'b0;
        if (i_clear) begin
            wp_n    = '0;
            count_n = '0;
            idx_n   = AW'(1);
        end else if (roll_end) begin
            ring_n[wp] = i_rand;
            wp_n       = wp + AW'(1);
            if (o_count != CW'(DEPTH))
                count_n = o_count + CW'(1);
            idx_n = AW'(1);
            cap_n = 1'b1;
        end else if (i_prev && o_count >= CW'(2)) begin
            if (CW'(o_hist_idx) == o_count - CW'(1))
                idx_n = AW'(1);
            else
                idx_n = o_hist_idx + AW'(1);
        end
    end

    // Views are taken from the post-update history so a capture shows at once.
    always_comb begin
        cur_val    = i_busy ? i_rand : ring_n[wp_n - AW'(1)];
        cur_blank  = !i_busy && (count_n == '0);
        hist_val   = ring_n[wp_n - AW'(1) - idx_n];
        hist_blank = !(CW'(idx_n) < count_n);
    end

    seg7_hex_decoder u_dec_cur (
        .i_hex   (cur_val),
        .i_blank (cur_blank),
        .o_seg   (cur_seg)
    );

    seg7_hex_decoder u_dec_hist (
        .i_hex   (hist_val),
        .i_blank (hist_blank),
        .o_seg   (hist_seg)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            wp         <= '0;
            o_count    <= '0;
            o_hist_idx <= AW'(1);
            o_capture  <= 1'b0;
            o_seg_cur  <= SEG_BLANK;
            o_seg_hist <= SEG_BLANK;
            for (int i = 0; i < DEPTH; i++)
                ring[i] <= '0;
        end else begin
            state      <= i_busy ? S_ROLL : S_IDLE;
            wp         <= wp_n;
            o_count    <= count_n;
            o_hist_idx <= idx_n;
            o_capture  <= cap_n;
            o_seg_cur  <= cur_seg;
            o_seg_hist <= hist_seg;
            for (int i = 0; i < DEPTH; i++)
                ring[i] <= ring_n[i];
        end
    end

endmodule

// File: tb/tb_rng_result_recorder.sv
// Self-checking bench for rng_result_recorder: directed table, corner
// sequences and randomized traffic against a queue-based history model.
module tb_rng_result_recorder;

    localparam int DEPTH = 4;

    localparam logic [7:0] HEXT [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic [3:0] i_rand = '0;
    logic       i_busy = 1'b0;
    logic       i_prev = 1'b0;
    logic       i_clear = 1'b0;
    logic [6:0] o_seg_cur, o_seg_hist;
    logic [1:0] o_hist_idx;
    logic [2:0] o_count;
    logic       o_capture;

    int n_vec = 0;
    int n_err = 0;

    // behavioural model: q[0] is the newest result
    logic [3:0] q[$];
    int         m_idx;
    bit         m_busy_d;
    logic [7:0] e_cur, e_hist;
    bit         e_cap;

    typedef struct {
        bit         busy;
        logic [3:0] r;
        bit         prev;
        bit         clr;
        logic [7:0] cur;
        logic [7:0] hist;
        int         cnt;
        int         idx;
        bit         cap;
    } vec_t;

    vec_t tbl[$];

    always #5 i_clk = ~i_clk;

    rng_result_recorder #(.DEPTH(DEPTH), .W(4)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_rand     (i_rand),
        .i_busy     (i_busy),
        .i_prev     (i_prev),
        .i_clear    (i_clear),
        .o_seg_cur  (o_seg_cur),
        .o_seg_hist (o_seg_hist),
        .o_hist_idx (o_hist_idx),
        .o_count    (o_count),
        .o_capture  (o_capture)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        m_idx    = 1;
        m_busy_d = 1'b0;
        e_cur    = 8'h7F;
        e_hist   = 8'h7F;
        e_cap    = 1'b0;
    endfunction

    function automatic void model_step(bit b, logic [3:0] r, bit p, bit c);
        bit ends;
        ends  = m_busy_d && !b;
        e_cap = 1'b0;
        if (c) begin
            q.delete();
            m_idx = 1;
        end else if (ends) begin
            q.push_front(r);
            if (q.size() > DEPTH)
                void'(q.pop_back());
            m_idx = 1;
            e_cap = 1'b1;
        end else if (p && q.size() >= 2) begin
            m_idx = (m_idx == q.size() - 1) ? 1 : m_idx + 1;
        end
        m_busy_d = b;
        if (b)
            e_cur = HEXT[r];
        else if (q.size() > 0)
            e_cur = HEXT[q[0]];
        else
            e_cur = 8'h7F;
        e_hist = (m_idx < q.size()) ? HEXT[q[m_idx]] : 8'h7F;
    endfunction

    task automatic step(input bit b, input logic [3:0] r, input bit p,
                        input bit c);
        i_busy  = b;
        i_rand  = r;
        i_prev  = p;
        i_clear = c;
        @(posedge i_clk);
        #1;
        model_step(b, r, p, c);
        chk("m_cur",  32'(o_seg_cur),  32'(e_cur[6:0]));
        chk("m_hist", 32'(o_seg_hist), 32'(e_hist[6:0]));
        chk("m_cnt",  32'(o_count),    32'(q.size()));
        chk("m_idx",  32'(o_hist_idx), 32'(m_idx));
        chk("m_cap",  32'(o_capture),  32'(e_cap));
    endtask

    task automatic add(input bit b, input logic [3:0] r, input bit p,
                       input bit c, input logic [7:0] cur,
                       input logic [7:0] hist, input int cnt,
                       input int idx, input bit cap);
        vec_t v;
        v.busy = b; v.r = r; v.prev = p; v.clr = c;
        v.cur = cur; v.hist = hist; v.cnt = cnt; v.idx = idx; v.cap = cap;
        tbl.push_back(v);
    endtask

    initial begin
        // roll 3,7,A,2,9 then end on 9
        add(1, 4'h3, 0, 0, 8'hB0, 8'h7F, 0, 1, 0);
        add(1, 4'h7, 0, 0, 8'hF8, 8'h7F, 0, 1, 0);
        add(1, 4'hA, 0, 0, 8'h88, 8'h7F, 0, 1, 0);
        add(1, 4'h2, 0, 0, 8'hA4, 8'h7F, 0, 1, 0);
        add(1, 4'h9, 0, 0, 8'h90, 8'h7F, 0, 1, 0);
        add(0, 4'h9, 0, 0, 8'h90, 8'h7F, 1, 1, 1);
        add(0, 4'h0, 0, 0, 8'h90, 8'h7F, 1, 1, 0);
        // five rolls ending on 1..5
        add(1, 4'h1, 0, 0, 8'hF9, 8'h7F, 1, 1, 0);
        add(0, 4'h1, 0, 0, 8'hF9, 8'h90, 2, 1, 1);
        add(1, 4'h2, 0, 0, 8'hA4, 8'h90, 2, 1, 0);
        add(0, 4'h2, 0, 0, 8'hA4, 8'hF9, 3, 1, 1);
        add(1, 4'h3, 0, 0, 8'hB0, 8'hF9, 3, 1, 0);
        add(0, 4'h3, 0, 0, 8'hB0, 8'hA4, 4, 1, 1);
        add(1, 4'h4, 0, 0, 8'h99, 8'hA4, 4, 1, 0);
        add(0, 4'h4, 0, 0, 8'h99, 8'hB0, 4, 1, 1);
        add(1, 4'h5, 0, 0, 8'h92, 8'hB0, 4, 1, 0);
        add(0, 4'h5, 0, 0, 8'h92, 8'h99, 4, 1, 1);
        // browse: 3, 2, then wrap to 4
        add(0, 4'h0, 1, 0, 8'h92, 8'hB0, 4, 2, 0);
        add(0, 4'h0, 1, 0, 8'h92, 8'hA4, 4, 3, 0);
        add(0, 4'h0, 1, 0, 8'h92, 8'h99, 4, 1, 0);
        // reach idx 3, then roll end with i_prev in the same cycle
        add(0, 4'h0, 1, 0, 8'h92, 8'hB0, 4, 2, 0);
        add(0, 4'h0, 1, 0, 8'h92, 8'hA4, 4, 3, 0);
        add(1, 4'h7, 0, 0, 8'hF8, 8'hA4, 4, 3, 0);
        add(0, 4'h7, 1, 0, 8'hF8, 8'h92, 4, 1, 1);

        model_reset();
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_cur",  32'(o_seg_cur),  32'h7F);
        chk("rst_hist", 32'(o_seg_hist), 32'h7F);
        chk("rst_idx",  32'(o_hist_idx), 32'd1);
        chk("rst_cnt",  32'(o_count),    32'd0);
        chk("rst_cap",  32'(o_capture),  32'd0);
        i_rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            step(0, 4'(i), 0, 0);
        chk("idle_cur",  32'(o_seg_cur),  32'h7F);
        chk("idle_hist", 32'(o_seg_hist), 32'h7F);
        chk("idle_cnt",  32'(o_count),    32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].busy, tbl[i].r, tbl[i].prev, tbl[i].clr);
            chk($sformatf("t%0d_cur", i),  32'(o_seg_cur),  32'(tbl[i].cur[6:0]));
            chk($sformatf("t%0d_hist", i), 32'(o_seg_hist), 32'(tbl[i].hist[6:0]));
            chk($sformatf("t%0d_cnt", i),  32'(o_count),    32'(tbl[i].cnt));
            chk($sformatf("t%0d_idx", i),  32'(o_hist_idx), 32'(tbl[i].idx));
            chk($sformatf("t%0d_cap", i),  32'(o_capture),  32'(tbl[i].cap));
        end

        // clear in the same cycle as a roll end
        step(1, 4'h6, 0, 0);
        step(0, 4'h6, 0, 1);
        chk("clr_cap",  32'(o_capture),  32'd0);
        chk("clr_cnt",  32'(o_count),    32'd0);
        chk("clr_cur",  32'(o_seg_cur),  32'h7F);
        chk("clr_hist", 32'(o_seg_hist), 32'h7F);
        chk("clr_idx",  32'(o_hist_idx), 32'd1);

        // reset mid-roll, busy dropped while in reset
        step(1, 4'h8, 0, 0);
        step(1, 4'h8, 0, 0);
        i_rst_n = 1'b0;
        i_busy  = 1'b0;
        #1;
        model_reset();
        chk("mrst_cur", 32'(o_seg_cur), 32'h7F);
        chk("mrst_cnt", 32'(o_count),   32'd0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        step(0, 4'h8, 0, 0);
        step(0, 4'h8, 0, 0);
        chk("mrst_nocap", 32'(o_capture), 32'd0);
        chk("mrst_cnt2",  32'(o_count),   32'd0);
        step(1, 4'hC, 0, 0);
        step(0, 4'hC, 0, 0);
        chk("post_cap", 32'(o_capture), 32'd1);
        chk("post_cnt", 32'(o_count),   32'd1);
        chk("post_cur", 32'(o_seg_cur), 32'h46);

        // randomized traffic
        begin
            bit b = 1'b0;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 3) == 0)
                    b = ~b;
                step(b, 4'($urandom), ($urandom_range(0, 5) == 0),
                     ($urandom_range(0, 49) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
